// File: rtl/snax_tcdm_responder.sv
// -----------------------------------------------------------------------------
// snax_tcdm_responder
//
// Word-addressed TCDM slave memory with byte-enable writes and a fixed-latency
// read response pipeline. Reads are answered exactly ReadLatency cycles after
// acceptance. Writes produce no response. Accepted reads and writes are counted
// with saturating 32-bit counters.
//
// Optional feature macro: SNAX_TCDM_RESP_STALL_EN
//   defined   : a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//               randomly deasserts tcdm_q_ready_o to exercise requester stalls.
//   undefined : tcdm_q_ready_o is tied high and no LFSR exists.
//
// Ports
//   clk_i           in   clock, rising edge
//   rst_ni          in   asynchronous active-low reset
//   tcdm_q_valid_i  in   request valid
//   tcdm_q_ready_o  out  request ready (accept = valid & ready)
//   tcdm_q_addr_i   in   byte address [AddrWidth]
//   tcdm_q_write_i  in   1 = write, 0 = read
//   tcdm_q_data_i   in   write data [DataWidth]
//   tcdm_q_strb_i   in   byte write enables [DataWidth/8]
//   tcdm_p_valid_o  out  read response valid, single-cycle pulse
//   tcdm_p_data_o   out  read data, holds last value while valid is low
//   rd_cnt_o        out  accepted reads since reset (saturating)
//   wr_cnt_o        out  accepted writes since reset (saturating)
// -----------------------------------------------------------------------------
module snax_tcdm_responder #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DepthWords  = 256,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tcdm_q_valid_i,
    output logic                   tcdm_q_ready_o,
    input  logic [AddrWidth-1:0]   tcdm_q_addr_i,
    input  logic                   tcdm_q_write_i,
    input  logic [DataWidth-1:0]   tcdm_q_data_i,
    input  logic [DataWidth/8-1:0] tcdm_q_strb_i,
    output logic                   tcdm_p_valid_o,
    output logic [DataWidth-1:0]   tcdm_p_data_o,
    output logic [31:0]            rd_cnt_o,
    output logic [31:0]            wr_cnt_o
);

    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned OffsetBits = $clog2(StrbWidth);
    localparam int unsigned IndexBits  = $clog2(DepthWords);

    // ------------------------------------------------------------------
    // Request handshake
    // ------------------------------------------------------------------
    logic                 req_fire;
    logic                 rd_fire;
    logic                 wr_fire;
    logic [IndexBits-1:0] word_idx;
    logic [StrbWidth-1:0] byte_we;

    assign req_fire = tcdm_q_valid_i & tcdm_q_ready_o;
    assign rd_fire  = req_fire & ~tcdm_q_write_i;
    assign wr_fire  = req_fire &  tcdm_q_write_i;

    // Upper address bits are deliberately ignored: addresses alias modulo
    // the storage size. Byte-offset bits below the word are ignored too.
    assign word_idx = tcdm_q_addr_i[OffsetBits +: IndexBits];

    logic unused_addr_bits;
    assign unused_addr_bits = ^tcdm_q_addr_i;

    genvar gi;
    generate
        for (gi = 0; gi < StrbWidth; gi++) begin : g_byte_we
            assign byte_we[gi] = wr_fire & tcdm_q_strb_i[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage: no reset so it maps onto block RAM; contents survive reset.
    // ------------------------------------------------------------------
    logic [DataWidth-1:0] mem_reg [DepthWords];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < StrbWidth; b++) begin
            if (byte_we[b]) begin
                mem_reg[word_idx][b*8 +: 8] <= tcdm_q_data_i[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read response pipeline. Stage 0 is the registered RAM read taken at
    // the accept edge; each further stage adds one cycle. Data stages only
    // load when a valid word moves into them, so the output stage naturally
    // holds the last response while valid is low.
    // ------------------------------------------------------------------
    logic [ReadLatency-1:0] valid_pipe_reg;
    logic [DataWidth-1:0]   data_pipe_reg [ReadLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_pipe_reg <= '0;
            for (int s = 0; s < ReadLatency; s++) begin
                data_pipe_reg[s] <= '0;
            end
        end else begin
            valid_pipe_reg[0] <= rd_fire;
            if (rd_fire) begin
                data_pipe_reg[0] <= mem_reg[word_idx];
            end
            for (int s = 1; s < ReadLatency; s++) begin
                valid_pipe_reg[s] <= valid_pipe_reg[s-1];
                if (valid_pipe_reg[s-1]) begin
                    data_pipe_reg[s] <= data_pipe_reg[s-1];
                end
            end
        end
    end

    assign tcdm_p_valid_o = valid_pipe_reg[ReadLatency-1];
    assign tcdm_p_data_o  = data_pipe_reg[ReadLatency-1];

    // ------------------------------------------------------------------
    // Saturating request counters
    // ------------------------------------------------------------------
    logic [31:0] rd_cnt_reg;
    logic [31:0] wr_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else begin
            if (rd_fire && (rd_cnt_reg != 32'hFFFF_FFFF)) begin
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
            end
            if (wr_fire && (wr_cnt_reg != 32'hFFFF_FFFF)) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_reg;
    assign wr_cnt_o = wr_cnt_reg;

    // ------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------
`ifdef SNAX_TCDM_RESP_STALL_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    // Fibonacci form: feedback from taps 16,14,13,11 shifts in at bit 0.
    assign lfsr_next = {lfsr_reg[14:0],
                        lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    // Seed has bit 0 set, so ready is low in the first cycle after reset.
    assign tcdm_q_ready_o = ~lfsr_reg[0];
`else
    assign tcdm_q_ready_o = 1'b1;
`endif

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for snax_tcdm_responder (DataWidth 32, DepthWords 256,
// ReadLatency 3). A behavioural reference keeps a word array and a queue of
// expected responses tagged with their due cycle; a negedge monitor checks
// every output cycle against it. Directed steps then random traffic.
// Works with and without SNAX_TCDM_RESP_STALL_EN defined.
// -----------------------------------------------------------------------------
module tb_snax_tcdm_responder;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 256;
    localparam int L = 3;

    logic          clk_i;
    logic          rst_ni;
    logic          tcdm_q_valid_i;
    logic          tcdm_q_ready_o;
    logic [AW-1:0] tcdm_q_addr_i;
    logic          tcdm_q_write_i;
    logic [DW-1:0] tcdm_q_data_i;
    logic [3:0]    tcdm_q_strb_i;
    logic          tcdm_p_valid_o;
    logic [DW-1:0] tcdm_p_data_o;
    logic [31:0]   rd_cnt_o;
    logic [31:0]   wr_cnt_o;

    snax_tcdm_responder #(
        .DataWidth   (DW),
        .AddrWidth   (AW),
        .DepthWords  (DEPTH),
        .ReadLatency (L)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tcdm_q_valid_i (tcdm_q_valid_i),
        .tcdm_q_ready_o (tcdm_q_ready_o),
        .tcdm_q_addr_i  (tcdm_q_addr_i),
        .tcdm_q_write_i (tcdm_q_write_i),
        .tcdm_q_data_i  (tcdm_q_data_i),
        .tcdm_q_strb_i  (tcdm_q_strb_i),
        .tcdm_p_valid_o (tcdm_p_valid_o),
        .tcdm_p_data_o  (tcdm_p_data_o),
        .rd_cnt_o       (rd_cnt_o),
        .wr_cnt_o       (wr_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic [31:0] model_mem [DEPTH];
    exp_t        exp_q[$];
    int          resp_cyc[$];
    logic [31:0] last_data = '0;
    int          rd_exp = 0;
    int          wr_exp = 0;
    int          txn_no = 0;

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // Output monitor: every cycle compare against the expected-response queue.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("rst_p_valid", {31'b0, tcdm_p_valid_o}, 32'd0);
            chk("rst_p_data", tcdm_p_data_o, 32'd0);
            chk("rst_rd_cnt", rd_cnt_o, 32'd0);
            chk("rst_wr_cnt", wr_cnt_o, 32'd0);
`ifndef SNAX_TCDM_RESP_STALL_EN
            chk("rst_ready", {31'b0, tcdm_q_ready_o}, 32'd1);
`endif
            last_data = '0;
        end else begin
            logic exp_v;
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("p_valid", {31'b0, tcdm_p_valid_o}, {31'b0, exp_v});
            if (exp_v) begin
                chk("p_data", tcdm_p_data_o, exp_q[0].data);
                last_data = exp_q[0].data;
                void'(exp_q.pop_front());
                resp_cyc.push_back(cyc);
            end else begin
                chk("p_data_hold", tcdm_p_data_o, last_data);
            end
`ifndef SNAX_TCDM_RESP_STALL_EN
            chk("ready_high", {31'b0, tcdm_q_ready_o}, 32'd1);
`endif
        end
    end

    // Issue one request, hold it until accepted, update the model at acceptance.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output int acc);
        int tries;
        tries = 0;
        acc = -1;
        @(negedge clk_i);
        tcdm_q_valid_i = 1'b1;
        tcdm_q_write_i = wr;
        tcdm_q_addr_i  = addr;
        tcdm_q_data_i  = data;
        tcdm_q_strb_i  = strb;
        while (tcdm_q_ready_o !== 1'b1 && tries <= 200) begin
            tries++;
            @(negedge clk_i);
        end
        if (tcdm_q_ready_o !== 1'b1) begin
            chk("ready_timeout", {31'b0, tcdm_q_ready_o}, 32'd1);
            tcdm_q_valid_i = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[word_of(addr)][b*8 +: 8] = data[b*8 +: 8];
            wr_exp++;
        end else begin
            exp_q.push_back('{data: model_mem[word_of(addr)], due: acc + L - 1});
            rd_exp++;
        end
        txn_no++;
        $display("txn %0d %s addr=%h data=%h strb=%h acc_cycle=%0d", txn_no,
                 wr ? "WR" : "RD", addr, wr ? data : model_mem[word_of(addr)], strb, acc);
        @(posedge clk_i);
        #1 tcdm_q_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int acc, input logic [31:0] exp_data);
        int n;
        n = 0;
        while (tcdm_p_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_seen"}, {31'b0, tcdm_p_valid_o}, 32'd1);
        chk({tag, "_latency"}, cyc - acc + 1, L);
        chk({tag, "_data"}, tcdm_p_data_o, exp_data);
    endtask

    task automatic apply_reset();
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        exp_q.delete();
        rd_exp = 0;
        wr_exp = 0;
        #1;
        chk("async_rst_p_valid", {31'b0, tcdm_p_valid_o}, 32'd0);
        chk("async_rst_p_data", tcdm_p_data_o, 32'd0);
        chk("async_rst_rd_cnt", rd_cnt_o, 32'd0);
        chk("async_rst_wr_cnt", wr_cnt_o, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
`ifdef SNAX_TCDM_RESP_STALL_EN
        chk("ready_first_cycle", {31'b0, tcdm_q_ready_o}, 32'd0);
`else
        chk("ready_first_cycle", {31'b0, tcdm_q_ready_o}, 32'd1);
`endif
    endtask

    initial begin
        int acc;
        int n_before;
        logic [31:0] a;
        tcdm_q_valid_i = 1'b0;
        tcdm_q_write_i = 1'b0;
        tcdm_q_addr_i  = '0;
        tcdm_q_data_i  = '0;
        tcdm_q_strb_i  = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
`ifndef SNAX_TCDM_RESP_STALL_EN
        chk("ready_in_reset", {31'b0, tcdm_q_ready_o}, 32'd1);
`endif
        rst_ni = 1'b1;
        #1;
`ifdef SNAX_TCDM_RESP_STALL_EN
        chk("ready_first_cycle", {31'b0, tcdm_q_ready_o}, 32'd0);
`endif

        // Full write then read back with latency check.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, acc);
        wait_resp("full_wr_rd", acc, 32'hDEADBEEF);

        // Partial write of the low half.
        do_req(1'b1, 32'h10, 32'h0000_1234, 4'h3, acc);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, acc);
        wait_resp("partial_wr", acc, 32'hDEAD1234);

        // Address aliasing: 0x400 wraps onto word 0.
        do_req(1'b1, 32'h400, 32'h55, 4'hF, acc);
        do_req(1'b0, 32'h000, 32'h0, 4'h0, acc);
        wait_resp("alias_wrap", acc, 32'h55);
        repeat (L + 2) @(negedge clk_i);
        chk("rd_cnt_directed", rd_cnt_o, rd_exp);
        chk("wr_cnt_directed", wr_cnt_o, wr_exp);

        // Fill every word so later random reads have defined data.
        for (int w = 0; w < DEPTH; w++) do_req(1'b1, w * 4, $urandom, 4'hF, acc);

        // Reset keeps storage; counters restart.
        apply_reset();

        // Eight back-to-back reads.
        resp_cyc.delete();
        for (int i = 0; i < 8; i++) do_req(1'b0, i * 4 + 32'h100, 32'h0, 4'h0, acc);
        repeat (L + 3) @(negedge clk_i);
        chk("b2b_resp_count", resp_cyc.size(), 32'd8);
`ifndef SNAX_TCDM_RESP_STALL_EN
        if (resp_cyc.size() == 8) chk("b2b_consecutive", resp_cyc[7] - resp_cyc[0], 32'd7);
`endif
        chk("b2b_rd_cnt", rd_cnt_o, 32'd8);

        // Reset with two reads in flight: they must never answer.
        do_req(1'b0, 32'h20, 32'h0, 4'h0, acc);
        do_req(1'b0, 32'h24, 32'h0, 4'h0, acc);
        n_before = resp_cyc.size();
        apply_reset();
        repeat (10) @(negedge clk_i);
        chk("dropped_resp_count", resp_cyc.size() - n_before, 32'd0);
        chk("drop_rd_cnt", rd_cnt_o, 32'd0);
        chk("drop_wr_cnt", wr_cnt_o, 32'd0);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), acc);
        end
        repeat (L + 3) @(negedge clk_i);
        chk("rand_queue_drained", exp_q.size(), 32'd0);
        chk("rand_rd_cnt", rd_cnt_o, rd_exp);
        chk("rand_wr_cnt", wr_cnt_o, wr_exp);
        chk("rand_total", rd_cnt_o + wr_cnt_o, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/snax_tcdm_responder.md
SNAX_TCDM_RESPONDER -- requirements
Module: snax_tcdm_responder

Interface
REQ-001 SHALL have parameter DataWidth, default 32; data width in bits (32 or 64).
REQ-002 SHALL have parameter AddrWidth, default 32; byte address width.
REQ-003 SHALL have parameter DepthWords, default 256; storage words (power of two, 2..4096).
REQ-004 SHALL have parameter ReadLatency, default 1; accept-to-response cycles for reads (1..4).
REQ-005 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port tcdm_q_valid_i  input  1  request valid.
REQ-008 SHALL have port tcdm_q_ready_o  output  1  request accepted when high with valid.
REQ-009 SHALL have port tcdm_q_addr_i  input  AddrWidth  byte address.
REQ-010 SHALL have port tcdm_q_write_i  input  1  1 = write, 0 = read.
REQ-011 SHALL have port tcdm_q_data_i  input  DataWidth  write data.
REQ-012 SHALL have port tcdm_q_strb_i  input  DataWidth/8  byte write enables.
REQ-013 SHALL have port tcdm_p_valid_o  output  1  read response valid, one-cycle pulse, no backpressure.
REQ-014 SHALL have port tcdm_p_data_o  output  DataWidth  read data.
REQ-015 SHALL have port rd_cnt_o  output  32  accepted reads since reset.
REQ-016 SHALL have port wr_cnt_o  output  32  accepted writes since reset.

Function
REQ-017 SHALL accept a request in a cycle where tcdm_q_valid_i and tcdm_q_ready_o are both high; at most one per cycle.
REQ-018 SHALL index storage with word address tcdm_q_addr_i[log2(DataWidth/8) +: log2(DepthWords)]; upper bits ignored (wrap-around aliasing).
REQ-019 SHALL on accepted write update only bytes with strb bit set, visible to any read accepted in the following cycle or later.
REQ-020 SHALL produce no response for writes.
REQ-021 SHALL on accepted read assert tcdm_p_valid_o exactly ReadLatency cycles later with the word value at acceptance time.
REQ-022 SHALL implement ReadLatency as a valid/data shift pipeline; back-to-back reads yield back-to-back responses in acceptance order.
REQ-023 SHALL hold tcdm_p_data_o at its last value when tcdm_p_valid_o is low.
REQ-024 SHALL keep tcdm_q_ready_o constantly high when SNAX_TCDM_RESP_STALL_EN is undefined.
REQ-025 SHALL increment rd_cnt_o / wr_cnt_o by one per accepted read / write, saturating at 32'hFFFF_FFFF.
REQ-026 SHALL not register valid-without-ready as a request; request fields may change freely while not accepted.

Reset
REQ-027 SHALL on rst_ni low immediately clear pipeline valid bits, tcdm_p_valid_o = 0, tcdm_p_data_o = 0, rd_cnt_o = 0, wr_cnt_o = 0.
REQ-028 SHALL drop in-flight reads on reset mid-operation; no response is emitted for them after release.
REQ-029 SHALL not reset storage contents.

Configuration
REQ-030 SHALL with macro SNAX_TCDM_RESP_STALL_EN defined include a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset seed 16'hACE1, advancing every cycle, driving tcdm_q_ready_o = ~lfsr[0].
REQ-031 SHALL with SNAX_TCDM_RESP_STALL_EN undefined contain no LFSR logic and drive tcdm_q_ready_o = 1 (also during reset).

Verification
REQ-032 SHALL verify write addr 0x10 data 0xDEADBEEF strb 0xF, then read 0x10 -> p_valid exactly ReadLatency cycles after read accept, data 0xDEADBEEF.
REQ-033 SHALL verify partial write strb 0x3 data 0x0000_1234 over 0xDEADBEEF at 0x10 -> read returns 0xDEAD1234.
REQ-034 SHALL verify DepthWords=256, DataWidth=32: write 0x400 data 0x55 then read 0x000 -> 0x55 (alias wrap).
REQ-035 SHALL verify 8 back-to-back reads with ReadLatency=3 -> 8 consecutive p_valid pulses in order, rd_cnt_o = 8.
REQ-036 SHALL verify rst_ni low one cycle after two reads accepted -> no p_valid after release, counters 0.
REQ-037 SHALL verify with SNAX_TCDM_RESP_STALL_EN: 1000 random requests held until ready -> every read answered correctly, rd_cnt_o+wr_cnt_o = 1000, q_ready low in first post-reset cycle.
